// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU codes, operand-B select codes, FSM states and control bundle for the execute stage
package ex_pkg;
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_LSL   = 4'b0011,
    ALU_LSR   = 4'b0100,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_MUL   = 4'b1000,
    ALU_NOR   = 4'b1100
  } alu_ctl_e;
  typedef enum logic [1:0] {SRC_RS2, SRC_IMM, SRC_UIMM, SRC_BAD} alu_src_e;
  typedef enum logic {S_IDLE, S_MUL} state_e;
  typedef struct packed {
    logic b, bz, bnz, mem_write, mem_read, mem_to_reg, reg_write, illegal;
    logic [4:0] rd;
  } ctl_t;
endpackage

// File: rtl/ex_stage_p_if.sv
// ex_stage_p_if: ID/EX input handshake and EX/MEM output handshake of the execute stage
interface ex_stage_p_if #(parameter int XLEN = 64);
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [31:0] in_instr;
  logic [1:0] in_alu_src;
  logic [3:0] in_alu_ctl;
  logic in_b, in_bz, in_bnz, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
  logic [4:0] in_rd;
  logic flush;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_result, out_store_data, out_branch_target;
  logic out_zero, out_pc_src, out_illegal;
  logic [4:0] out_rd;
  logic out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write;
  logic busy;
  modport slave (
    input in_valid, in_pc, in_instr, in_imm, in_rs1_data, in_rs2_data, in_alu_src, in_alu_ctl,
    input in_b, in_bz, in_bnz, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write, in_rd,
    input flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_branch_target,
    output out_zero, out_pc_src, out_illegal, out_rd,
    output out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write, busy
  );
  modport master (
    output in_valid, in_pc, in_instr, in_imm, in_rs1_data, in_rs2_data, in_alu_src, in_alu_ctl,
    output in_b, in_bz, in_bnz, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write, in_rd,
    output flush, out_ready,
    input in_ready, out_valid, out_result, out_store_data, out_branch_target,
    input out_zero, out_pc_src, out_illegal, out_rd,
    input out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write, busy
  );
endinterface

// File: rtl/ex_multiplier.sv
// ex_multiplier: radix-2 shift-add multiplier, one partial product per cycle, low XLEN bits kept
module ex_multiplier #(parameter int XLEN = 64) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN);
  logic run;
  logic [XLEN-1:0] acc, ma, mb;
  logic [CW-1:0] cnt;
  assign product = acc + (mb[0] ? ma : '0);
  assign done = run && cnt == CW'(XLEN - 1);
  // Iteration state: done pulses on the last step, product is valid in that same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      run <= 1'b0;
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
      cnt <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      acc <= '0;
      ma  <= a;
      mb  <= b;
      cnt <= '0;
    end else if (run) begin
      run <= !done;
      acc <= product;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ex_stage_p.sv
// ex_stage_p: LEGv8 execute stage with ALU, shifts, iterative multiply and a registered EX/MEM output
module ex_stage_p
  import ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input logic        clk,
  input logic        reset,
  ex_stage_p_if.slave io
);
  state_e state, state_n;
  logic accept, is_mul, start, load, mul_done, bad_op, unused;
  logic [XLEN-1:0] op_b, alu_res, mul_prod, target, h_store, h_target;
  logic [SHAMT_W-1:0] shamt;
  ctl_t ctl_in, h_ctl, ctl_q;
  assign shamt  = io.in_instr[10 +: SHAMT_W];
  assign unused = ^{io.in_instr[31:22], io.in_instr[9:0]};
  assign target = io.in_pc + (io.in_imm << 2);
  assign is_mul = io.in_alu_ctl == ALU_MUL;
  assign io.busy     = state == S_MUL;
  assign io.in_ready = !io.busy && (!io.out_valid || io.out_ready) && !io.flush;
  assign accept = io.in_valid && io.in_ready;
  assign start  = accept && is_mul;
  assign load   = !io.flush && ((accept && !is_mul) || mul_done);
  assign ctl_in = '{b: io.in_b, bz: io.in_bz, bnz: io.in_bnz, mem_write: io.in_mem_write,
                    mem_read: io.in_mem_read, mem_to_reg: io.in_mem_to_reg, reg_write: io.in_reg_write,
                    illegal: bad_op || io.in_alu_src == SRC_BAD, rd: io.in_rd};
  // Operand B select and single-cycle ALU; MUL result comes from the multiplier
  always_comb begin
    op_b = io.in_alu_src == SRC_RS2 ? io.in_rs2_data :
           io.in_alu_src == SRC_IMM ? io.in_imm :
           io.in_alu_src == SRC_UIMM ? XLEN'(io.in_instr[21:10]) : '0;
    alu_res = '0;
    bad_op  = 1'b0;
    case (io.in_alu_ctl)
      ALU_AND:   alu_res = io.in_rs1_data & op_b;
      ALU_OR:    alu_res = io.in_rs1_data | op_b;
      ALU_ADD:   alu_res = io.in_rs1_data + op_b;
      ALU_SUB:   alu_res = io.in_rs1_data - op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(io.in_rs1_data | op_b);
      ALU_LSL:   alu_res = io.in_rs1_data << shamt;
      ALU_LSR:   alu_res = io.in_rs1_data >> shamt;
      ALU_MUL:   alu_res = '0;
      default:   bad_op  = 1'b1;
    endcase
  end
  ex_multiplier #(.XLEN(XLEN)) u_mul (
    .clk(clk), .reset(reset), .start(start), .abort(io.flush),
    .a(io.in_rs1_data), .b(op_b), .done(mul_done), .product(mul_prod)
  );
  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // FSM next state: flush aborts a multiply, done returns to idle
  always_comb begin
    state_n = io.flush ? S_IDLE :
              start ? S_MUL :
              (state == S_MUL && mul_done) ? S_IDLE : state;
  end
  // Side information of a multiply is captured at acceptance, inputs are free to change while it runs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_store  <= '0;
      h_target <= '0;
      h_ctl    <= '0;
    end else if (start) begin
      h_store  <= io.in_rs2_data;
      h_target <= target;
      h_ctl    <= ctl_in;
    end
  // EX/MEM register: flush drops valid, a load may replace a result drained on the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      io.out_valid         <= 1'b0;
      io.out_result        <= '0;
      io.out_zero          <= 1'b0;
      io.out_store_data    <= '0;
      io.out_branch_target <= '0;
      ctl_q                <= '0;
    end else begin
      io.out_valid <= io.flush ? 1'b0 : load ? 1'b1 : io.out_valid && !io.out_ready;
      if (load) begin
        io.out_result        <= mul_done ? mul_prod : alu_res;
        io.out_zero          <= (mul_done ? mul_prod : alu_res) == '0;
        io.out_store_data    <= mul_done ? h_store : io.in_rs2_data;
        io.out_branch_target <= mul_done ? h_target : target;
        ctl_q                <= mul_done ? h_ctl : ctl_in;
      end
    end
  assign io.out_rd         = ctl_q.rd;
  assign io.out_illegal    = ctl_q.illegal;
  assign io.out_mem_write  = ctl_q.mem_write;
  assign io.out_mem_read   = ctl_q.mem_read;
  assign io.out_mem_to_reg = ctl_q.mem_to_reg;
  assign io.out_reg_write  = ctl_q.reg_write;
  assign io.out_pc_src     = io.out_valid && (ctl_q.b || (ctl_q.bz && io.out_zero) || (ctl_q.bnz && !io.out_zero));
endmodule

// File: tb/tb_ex_stage_p.sv
// tb_ex_stage_p: directed vector table plus hand-written multiply, stall, flush and reset sequences
module tb_ex_stage_p;
  import ex_pkg::*;
  localparam int XLEN = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] got[$];
  ex_stage_p_if #(.XLEN(XLEN)) io();
  ex_stage_p #(.XLEN(XLEN), .SHAMT_W(6)) dut (.clk(clk), .reset(reset), .io(io.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] ctl;
    logic [1:0] src;
    logic [63:0] a, b, imm, pc;
    logic [31:0] instr;
    logic [2:0] br;
    logic [4:0] rd;
    logic [3:0] mem;
    logic [63:0] res;
    logic zero, ill, pcs;
    logic [63:0] tgt;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    if (io.out_valid && io.out_ready) got.push_back(io.out_result);
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    vec_t x = '{default: '0};
    x.ctl = c;
    x.a = a;
    x.b = b;
    return x;
  endfunction
  task automatic drive(input vec_t x);
    io.in_alu_ctl = x.ctl;
    io.in_alu_src = x.src;
    io.in_rs1_data = x.a;
    io.in_rs2_data = x.b;
    io.in_imm = x.imm;
    io.in_pc = x.pc;
    io.in_instr = x.instr;
    {io.in_b, io.in_bz, io.in_bnz} = x.br;
    io.in_rd = x.rd;
    {io.in_mem_write, io.in_mem_read, io.in_mem_to_reg, io.in_reg_write} = x.mem;
  endtask
  task automatic accept_op(input vec_t x);
    drive(x);
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int bad, n;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.flush = 1'b0;
    drive(mk(4'h0, 64'd0, 64'd0));
    v[0]  = '{4'h2, 2'b01, 64'd5, 64'h77, 64'hFFFF_FFFF_FFFF_FFFB, 64'h1000, 32'h0, 3'b010, 5'd1, 4'b0001, 64'd0, 1'b1, 1'b0, 1'b1, 64'hFEC};
    v[1]  = '{4'h6, 2'b00, 64'd10, 64'd3, 64'd4, 64'h2000, 32'h0, 3'b001, 5'd2, 4'b1000, 64'd7, 1'b0, 1'b0, 1'b1, 64'h2010};
    v[2]  = '{4'h0, 2'b00, 64'hF0F0, 64'hFF00, 64'd0, 64'h3000, 32'h0, 3'b010, 5'd3, 4'b0100, 64'hF000, 1'b0, 1'b0, 1'b0, 64'h3000};
    v[3]  = '{4'h1, 2'b00, 64'hF0F0, 64'h0F0F, 64'd1, 64'h3000, 32'h0, 3'b000, 5'd4, 4'b0011, 64'hFFFF, 1'b0, 1'b0, 1'b0, 64'h3004};
    v[4]  = '{4'hC, 2'b00, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 32'h0, 3'b000, 5'd5, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'hC};
    v[5]  = '{4'h7, 2'b10, 64'd0, 64'd0, 64'd0, 64'd0, 32'h002A_F000, 3'b000, 5'd6, 4'b0000, 64'hABC, 1'b0, 1'b0, 1'b0, 64'd0};
    v[6]  = '{4'h3, 2'b00, 64'd1, 64'd0, 64'd0, 64'd0, 32'h0000_FC00, 3'b000, 5'd7, 4'b0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 64'd0};
    v[7]  = '{4'h4, 2'b00, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0, 32'h0000_FC00, 3'b000, 5'd8, 4'b0000, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0};
    v[8]  = '{4'h3, 2'b00, 64'hFF, 64'd0, 64'd0, 64'd0, 32'h0000_1000, 3'b000, 5'd9, 4'b0000, 64'hFF0, 1'b0, 1'b0, 1'b0, 64'd0};
    v[9]  = '{4'hF, 2'b00, 64'd5, 64'd5, 64'd2, 64'h40, 32'h0, 3'b100, 5'd10, 4'b0000, 64'd0, 1'b1, 1'b1, 1'b1, 64'h48};
    v[10] = '{4'h7, 2'b11, 64'd0, 64'd9, 64'd0, 64'd0, 32'h0, 3'b001, 5'd11, 4'b0000, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0};
    v[11] = '{4'h2, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 32'h0, 3'b000, 5'd12, 4'b0000, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0};
    v[12] = '{4'h6, 2'b00, 64'd0, 64'd1, 64'd0, 64'd0, 32'h0, 3'b010, 5'd13, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd0};
    v[13] = '{4'h2, 2'b00, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 3'b000, 5'd31, 4'b1111, 64'd5, 1'b0, 1'b0, 1'b0, 64'd0};
    v[14] = '{4'h4, 2'b00, 64'hF0, 64'd0, 64'd0, 64'd0, 32'h0000_1000, 3'b000, 5'd14, 4'b0000, 64'hF, 1'b0, 1'b0, 1'b0, 64'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy held", io.busy, 0);
    reset = 1'b0;
    #1;
    chk("reset out_valid", io.out_valid, 0);
    chk("reset in_ready", io.in_ready, 1);
    chk("reset busy", io.busy, 0);
    chk("reset result", io.out_result, 0);
    chk("reset target", io.out_branch_target, 0);
    chk("reset pc_src", io.out_pc_src, 0);
    chk("reset illegal", io.out_illegal, 0);
    chk("reset rd", io.out_rd, 0);
    chk("reset zero", io.out_zero, 0);
    step();
    for (int i = 0; i < 15; i++) begin
      accept_op(v[i]);
      chk($sformatf("v%0d out_valid", i), io.out_valid, 1);
      chk($sformatf("v%0d result", i), io.out_result, v[i].res);
      chk($sformatf("v%0d zero", i), io.out_zero, v[i].zero);
      chk($sformatf("v%0d illegal", i), io.out_illegal, v[i].ill);
      chk($sformatf("v%0d pc_src", i), io.out_pc_src, v[i].pcs);
      chk($sformatf("v%0d target", i), io.out_branch_target, v[i].tgt);
      chk($sformatf("v%0d store_data", i), io.out_store_data, v[i].b);
      chk($sformatf("v%0d rd", i), io.out_rd, v[i].rd);
      chk($sformatf("v%0d mem ctl", i), {io.out_mem_write, io.out_mem_read, io.out_mem_to_reg, io.out_reg_write}, v[i].mem);
    end
    step();
    chk("drained pc_src", io.out_pc_src, 0);
    chk("drained out_valid", io.out_valid, 0);
    accept_op(mk(4'h8, 64'hFFFF_FFFF, 64'h1_0000_0001));
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (!(io.busy === 1'b1 && io.in_ready === 1'b0 && io.out_valid === 1'b0)) bad++;
      step();
    end
    chk("mul busy window", bad, 0);
    chk("mul out_valid", io.out_valid, 1);
    chk("mul busy done", io.busy, 0);
    chk("mul result", io.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mul zero", io.out_zero, 0);
    begin
      vec_t m = mk(4'h8, 64'h8000_0000_0000_0001, 64'd3);
      m.rd = 5'd7;
      m.mem = 4'b0001;
      m.b = 64'd3;
      accept_op(m);
    end
    drive(mk(4'h2, 64'd1, 64'd1));
    n = 0;
    while (!io.out_valid && n < 100) begin
      step();
      n++;
    end
    chk("mul2 latency", n, 64);
    chk("mul2 result", io.out_result, 64'h8000_0000_0000_0003);
    chk("mul2 rd", io.out_rd, 7);
    chk("mul2 reg_write", io.out_reg_write, 1);
    chk("mul2 store_data", io.out_store_data, 3);
    step();
    got.delete();
    io.out_ready = 1'b0;
    accept_op(mk(4'h2, 64'd1, 64'd1));
    drive(mk(4'h2, 64'd2, 64'd1));
    io.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d in_ready", k), io.in_ready, 0);
      chk($sformatf("stall%0d result", k), io.out_result, 2);
      chk($sformatf("stall%0d out_valid", k), io.out_valid, 1);
      step();
    end
    io.out_ready = 1'b1;
    step();
    drive(mk(4'h2, 64'd3, 64'd1));
    step();
    io.in_valid = 1'b0;
    step();
    step();
    chk("bp count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp order%0d", k), got.size() > k ? got[k] : 64'hx, 64'(k + 2));
    accept_op(mk(4'h8, 64'd3, 64'd5));
    repeat (9) step();
    chk("pre-flush busy", io.busy, 1);
    io.flush = 1'b1;
    io.in_valid = 1'b1;
    #1;
    chk("flush in_ready", io.in_ready, 0);
    step();
    io.flush = 1'b0;
    io.in_valid = 1'b0;
    chk("flush busy", io.busy, 0);
    chk("flush out_valid", io.out_valid, 0);
    bad = 0;
    repeat (70) begin
      if (io.out_valid) bad++;
      step();
    end
    chk("flush no result", bad, 0);
    accept_op(mk(4'h2, 64'd20, 64'd22));
    chk("post-flush valid", io.out_valid, 1);
    chk("post-flush result", io.out_result, 42);
    io.out_ready = 1'b0;
    step();
    chk("held valid", io.out_valid, 1);
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    chk("flush held valid", io.out_valid, 0);
    accept_op(mk(4'h8, 64'd7, 64'd9));
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("rst-mul busy", io.busy, 0);
    chk("rst-mul out_valid", io.out_valid, 0);
    chk("rst-mul result", io.out_result, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    repeat (70) begin
      if (io.out_valid) bad++;
      step();
    end
    chk("rst-mul no result", bad, 0);
    chk("rst-mul in_ready", io.in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
